// File: rtl/psk8_pkg.sv
// ---------------------------------------------------------------------------
// psk8_pkg
// Shared definitions for the 8-PSK symbol rotation multiplier and the
// 8-PSK slicer / de-rotator.
//   - SYM_*DEG     : 3-bit symbol codes indexed by constellation angle
//   - TAN_Q8       : tan(22.5 deg) * 256, sector boundary slope
//   - INV_SQRT2_Q8 : 1/sqrt(2) * 256, diagonal scaling
//   - conjSel()    : swap/negate/diagonal selects for multiplying by conj(s)
// ---------------------------------------------------------------------------
package psk8_pkg;

    localparam logic [2:0] SYM_0DEG   = 3'd7;
    localparam logic [2:0] SYM_45DEG  = 3'd6;
    localparam logic [2:0] SYM_90DEG  = 3'd2;
    localparam logic [2:0] SYM_135DEG = 3'd3;
    localparam logic [2:0] SYM_180DEG = 3'd1;
    localparam logic [2:0] SYM_225DEG = 3'd0;
    localparam logic [2:0] SYM_270DEG = 3'd4;
    localparam logic [2:0] SYM_315DEG = 3'd5;

    localparam int TAN_Q8       = 106;
    localparam int INV_SQRT2_Q8 = 181;

    // Multiplying by conj(s) is done as a quarter-turn de-rotation (swap and
    // negate the components) followed, for the odd-45-degree symbols, by one
    // extra -45 degree step: (x + y, y - x) scaled by 1/sqrt(2).
    typedef struct packed {
        logic swap;
        logic negRe;
        logic negIm;
        logic diag;
    } conj_sel_t;

    // Quarter-turn part per code: 0 deg keeps (re, im), 90 deg gives
    // (im, -re), 180 deg gives (-re, -im), 270 deg gives (-im, re).
    function automatic conj_sel_t conjSel(input logic [2:0] sym);
        conj_sel_t sel;
        sel = '0;
        case (sym)
            SYM_0DEG:   sel = 4'b0000;
            SYM_45DEG:  sel = 4'b0001;
            SYM_90DEG:  sel = 4'b1010;
            SYM_135DEG: sel = 4'b1011;
            SYM_180DEG: sel = 4'b0110;
            SYM_225DEG: sel = 4'b0111;
            SYM_270DEG: sel = 4'b1100;
            SYM_315DEG: sel = 4'b1101;
            default:    sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/psk8_derotate.sv
// ---------------------------------------------------------------------------
// psk8_derotate
// Combinational z * conj(s) for an 8-PSK symbol code.
//   re_i, im_i : signed components of z
//   sym_i      : symbol code of s
//   re_o, im_o : signed components of z * conj(s), low WIDTH bits
// Diagonal symbols use (sum * INV_SQRT2_Q8) >>> 8 in WIDTH+10 bits; inputs
// with magnitude >= 2^(WIDTH-2) may wrap.
// ---------------------------------------------------------------------------
module psk8_derotate #(
    parameter int WIDTH        = 32,
    parameter int INV_SQRT2_Q8 = psk8_pkg::INV_SQRT2_Q8
) (
    input  logic [WIDTH-1:0] re_i,
    input  logic [WIDTH-1:0] im_i,
    input  logic [2:0]       sym_i,
    output logic [WIDTH-1:0] re_o,
    output logic [WIDTH-1:0] im_o
);
    import psk8_pkg::*;

    localparam int XW = WIDTH + 10;
    localparam logic signed [XW-1:0] SCALE = XW'(INV_SQRT2_Q8);

    conj_sel_t             sel;
    logic signed [XW-1:0]  reExt;
    logic signed [XW-1:0]  imExt;
    logic signed [XW-1:0]  xRe;
    logic signed [XW-1:0]  xIm;
    logic signed [XW-1:0]  sumRe;
    logic signed [XW-1:0]  sumIm;
    logic signed [XW-1:0]  prodRe;
    logic signed [XW-1:0]  prodIm;

    // Quarter-turn first in the wide domain so negating the most negative
    // input cannot overflow, then the optional 45 degree step on top.
    always_comb begin
        sel   = conjSel(sym_i);
        reExt = XW'(signed'(re_i));
        imExt = XW'(signed'(im_i));
        xRe   = sel.swap ? imExt : reExt;
        xIm   = sel.swap ? reExt : imExt;
        if (sel.negRe) begin
            xRe = -xRe;
        end
        if (sel.negIm) begin
            xIm = -xIm;
        end
        sumRe  = xRe + xIm;
        sumIm  = xIm - xRe;
        prodRe = sumRe * SCALE;
        prodIm = sumIm * SCALE;
        if (sel.diag) begin
            re_o = WIDTH'(prodRe >>> 8);
            im_o = WIDTH'(prodIm >>> 8);
        end else begin
            re_o = WIDTH'(xRe);
            im_o = WIDTH'(xIm);
        end
    end

endmodule

// File: rtl/psk8_slicer.sv
// ---------------------------------------------------------------------------
// psk8_slicer
// Three-stage pipelined 8-PSK hard-decision slicer and de-rotator.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready = !out_valid || out_ready)
//   in_real, in_imag     : signed sample z
//   out_valid / out_ready: output handshake
//   out_sym              : nearest symbol code S
//   out_real, out_imag   : signed z * conj(s)
//   out_err              : |out_imag|, saturating (only with PSK8_SLICER_ERR_EN)
// Optional feature macro: PSK8_SLICER_ERR_EN
// ---------------------------------------------------------------------------
module psk8_slicer #(
    parameter int WIDTH        = 32,
    parameter int TAN_Q8       = psk8_pkg::TAN_Q8,
    parameter int INV_SQRT2_Q8 = psk8_pkg::INV_SQRT2_Q8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sym,
`ifdef PSK8_SLICER_ERR_EN
    output logic [WIDTH-2:0] out_err,
`endif
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag
);
    import psk8_pkg::*;

    localparam int AW = WIDTH - 1;
    localparam int PW = WIDTH + 9;
    localparam logic [PW-1:0] TAN_K = PW'(TAN_Q8);

    logic             enable;

    logic             s1Valid_q;
    logic [WIDTH-1:0] s1Re_q;
    logic [WIDTH-1:0] s1Im_q;
    logic             s1NegRe_q;
    logic             s1NegIm_q;
    logic [AW-1:0]    s1A_q;
    logic [AW-1:0]    s1B_q;

    logic [PW-1:0]    bScaled;
    logic [PW-1:0]    aScaled;
    logic [PW-1:0]    aTan;
    logic [PW-1:0]    bTan;
    logic [2:0]       decSym_d;

    logic             s2Valid_q;
    logic [WIDTH-1:0] s2Re_q;
    logic [WIDTH-1:0] s2Im_q;
    logic [2:0]       s2Sym_q;

    logic [WIDTH-1:0] drRe;
    logic [WIDTH-1:0] drIm;

    logic             outValid_q;
    logic [2:0]       outSym_q;
    logic [WIDTH-1:0] outReal_q;
    logic [WIDTH-1:0] outImag_q;

    // Magnitude in WIDTH-1 bits; the most negative value has no positive
    // twin, so it clamps to the largest positive magnitude.
    function automatic logic [AW-1:0] absSat(input logic [WIDTH-1:0] v);
        logic [AW-1:0] mag;
        if (!v[WIDTH-1]) begin
            mag = v[AW-1:0];
        end else if (v[AW-1:0] == '0) begin
            mag = '1;
        end else begin
            mag = AW'(-v);
        end
        return mag;
    endfunction

    // The whole pipe moves as one; a stalled result freezes every stage
    // behind it, so bubbles are kept rather than squeezed out.
    assign enable    = !outValid_q || out_ready;
    assign in_ready  = enable;
    assign out_valid = outValid_q;
    assign out_sym   = outSym_q;
    assign out_real  = outReal_q;
    assign out_imag  = outImag_q;

    // Stage 1 captures the sample together with its signs and saturated
    // magnitudes so the decision stage only has to compare products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Re_q    <= '0;
            s1Im_q    <= '0;
            s1NegRe_q <= 1'b0;
            s1NegIm_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
        end else if (enable) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Re_q    <= in_real;
                s1Im_q    <= in_imag;
                s1NegRe_q <= in_real[WIDTH-1];
                s1NegIm_q <= in_imag[WIDTH-1];
                s1A_q     <= absSat(in_real);
                s1B_q     <= absSat(in_imag);
            end
        end
    end

    // Sector decision: a ratio below tan(22.5) against either axis means the
    // sample sits on that axis; anything else, including exact ties and the
    // origin, is treated as diagonal.
    always_comb begin
        decSym_d = SYM_0DEG;
        bScaled  = PW'({s1B_q, 8'h00});
        aScaled  = PW'({s1A_q, 8'h00});
        aTan     = PW'(s1A_q) * TAN_K;
        bTan     = PW'(s1B_q) * TAN_K;
        if (bScaled < aTan) begin
            decSym_d = s1NegRe_q ? SYM_180DEG : SYM_0DEG;
        end else if (aScaled < bTan) begin
            decSym_d = s1NegIm_q ? SYM_270DEG : SYM_90DEG;
        end else begin
            case ({s1NegRe_q, s1NegIm_q})
                2'b00:   decSym_d = SYM_45DEG;
                2'b10:   decSym_d = SYM_135DEG;
                2'b11:   decSym_d = SYM_225DEG;
                default: decSym_d = SYM_315DEG;
            endcase
        end
    end

    // Stage 2 holds the decided symbol alongside the untouched sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            s2Re_q    <= '0;
            s2Im_q    <= '0;
            s2Sym_q   <= SYM_0DEG;
        end else if (enable) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Re_q  <= s1Re_q;
                s2Im_q  <= s1Im_q;
                s2Sym_q <= decSym_d;
            end
        end
    end

    psk8_derotate #(
        .WIDTH        (WIDTH),
        .INV_SQRT2_Q8 (INV_SQRT2_Q8)
    ) uDerotate (
        .re_i  (s2Re_q),
        .im_i  (s2Im_q),
        .sym_i (s2Sym_q),
        .re_o  (drRe),
        .im_o  (drIm)
    );

    // Stage 3 is the output register; it only reloads on a real result so
    // the presented values stay put across bubbles and stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outSym_q   <= SYM_0DEG;
            outReal_q  <= '0;
            outImag_q  <= '0;
        end else if (enable) begin
            outValid_q <= s2Valid_q;
            if (s2Valid_q) begin
                outSym_q  <= s2Sym_q;
                outReal_q <= drRe;
                outImag_q <= drIm;
            end
        end
    end

`ifdef PSK8_SLICER_ERR_EN
    // Angular-error proxy taken straight off the output register, so it
    // shares its latency, stall behaviour and reset value.
    assign out_err = absSat(outImag_q);
`else
    // No angular-error proxy in this build.
`endif

endmodule

// File: tb/tb_psk8_slicer.sv
// ---------------------------------------------------------------------------
// tb_psk8_slicer
// Self-checking bench for psk8_slicer (WIDTH = 32). Expected results come
// from an angle-based reference model and a scoreboard queue; directed
// vectors carry hand-computed results.
// ---------------------------------------------------------------------------
module tb_psk8_slicer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_real;
    logic [W-1:0] in_imag;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_sym;
    logic [W-1:0] out_real;
    logic [W-1:0] out_imag;
`ifdef PSK8_SLICER_ERR_EN
    logic [W-2:0] out_err;
`endif

    typedef struct {
        logic [2:0]   sym;
        logic [W-1:0] re;
        logic [W-1:0] im;
        int           acceptCycle;
        bit           checkLat;
    } exp_t;

    exp_t sb[$];
    exp_t dummy;
    int   total = 0;
    int   bad = 0;
    int   cycleNo = 0;

    always #5 clk = ~clk;

    psk8_slicer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
`ifdef PSK8_SLICER_ERR_EN
        .out_err   (out_err),
`endif
        .out_real  (out_real),
        .out_imag  (out_imag)
    );

    // Reference: pick the 45-degree sector from the axis/diagonal rules,
    // then multiply z by the conjugate of that unit phasor.
    function automatic exp_t refModel(input logic [W-1:0] reIn, input logic [W-1:0] imIn);
        exp_t       e;
        longint     re, im, a, b, xr, xi;
        int         k;
        int         cosTab[8];
        int         sinTab[8];
        logic [2:0] symTab[8];
        cosTab = '{1, 1, 0, -1, -1, -1, 0, 1};
        sinTab = '{0, 1, 1, 1, 0, -1, -1, -1};
        symTab = '{3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0, 3'd4, 3'd5};
        re = longint'(signed'(reIn));
        im = longint'(signed'(imIn));
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        if (b > 64'sd2147483647) b = 64'sd2147483647;
        if (256 * b < 106 * a) k = (re >= 0) ? 0 : 4;
        else if (256 * a < 106 * b) k = (im >= 0) ? 2 : 6;
        else if (im >= 0) k = (re >= 0) ? 1 : 3;
        else k = (re >= 0) ? 7 : 5;
        xr = re * cosTab[k] + im * sinTab[k];
        xi = im * cosTab[k] - re * sinTab[k];
        if (k % 2 == 1) begin
            xr = (xr * 181) >>> 8;
            xi = (xi * 181) >>> 8;
        end
        e.sym = symTab[k];
        e.re = xr[W-1:0];
        e.im = xi[W-1:0];
        e.acceptCycle = 0;
        e.checkLat = 1'b0;
        return e;
    endfunction

    function automatic logic [W-1:0] absModel(input logic [W-1:0] v);
        longint x;
        x = longint'(signed'(v));
        if (x < 0) x = -x;
        if (x > 64'sd2147483647) x = 64'sd2147483647;
        return x[W-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(want));
        end
    endtask

    // One clock cycle: drive at the falling edge, then check whatever the
    // DUT presents against the oldest pending expectation, and log an
    // accepted sample into the scoreboard.
    task automatic applyStimulus(input bit vIn, input logic [W-1:0] re, input logic [W-1:0] im,
                                 input bit rdy, input bit useExp, input exp_t given,
                                 input bit lat, output bit accepted);
        exp_t e;
        @(negedge clk);
        in_valid = vIn;
        in_real = re;
        in_imag = im;
        out_ready = rdy;
        cycleNo++;
        #1;
        if (out_valid) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("[TB] FAIL unexpected_output: got out_valid=1 expected no pending result");
            end
            if (sb.size() != 0) begin
                e = sb[0];
                checkOutput("out_sym", W'(out_sym), W'(e.sym));
                checkOutput("out_real", out_real, e.re);
                checkOutput("out_imag", out_imag, e.im);
`ifdef PSK8_SLICER_ERR_EN
                checkOutput("out_err", W'(out_err), absModel(e.im));
`endif
                if (out_ready) begin
                    if (e.checkLat) checkOutput("latency", W'(cycleNo - e.acceptCycle), 32'd3);
                    void'(sb.pop_front());
                end
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            e = useExp ? given : refModel(re, im);
            e.acceptCycle = cycleNo;
            e.checkLat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        bit acc;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, dummy, 1'b0, acc);
            n++;
        end
        checkOutput("drain_pending", W'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   dRe[13];
        int   dIm[13];
        int   dSym[13];
        int   dOutRe[13];
        int   dOutIm[13];
        int   bpRe[5];
        int   bpIm[5];
        int   n;
        int   rv;
        int   iv;
        bit   acc;
        bit   vIn;
        bit   rdy;
        exp_t g;

        dRe    = '{1000, 0, 1000, -1000, 256, 256, 0, -1000, -1000, 1000, 0, 1000, -707};
        dIm    = '{0, 1000, 1000, -1, 106, 105, 0, 1000, -1000, -1000, -1000, 300, -700};
        dSym   = '{7, 2, 6, 1, 6, 7, 6, 3, 0, 5, 4, 7, 0};
        dOutRe = '{1000, 1000, 1414, 1000, 255, 256, 0, 1414, 1414, 1414, 1000, 1000, 994};
        dOutIm = '{0, 0, 0, 1, -107, 105, 0, 0, 0, 0, 0, 300, -5};
        bpRe   = '{1000, -800, 300, -50, 5000};
        bpIm   = '{20, 790, -2000, -60, 5000};
        dummy  = refModel('0, '0);

        rst = 1'b1;
        in_valid = 1'b0;
        in_real = '0;
        in_imag = '0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", W'(out_valid), 32'd0);
        checkOutput("reset_out_sym", W'(out_sym), 32'd7);
        checkOutput("reset_out_real", out_real, 32'd0);
        checkOutput("reset_out_imag", out_imag, 32'd0);
        checkOutput("reset_in_ready", W'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors back to back, each must appear exactly 3 cycles on.
        $display("[TB] directed vectors");
        for (int i = 0; i < 13; i++) begin
            g.sym = 3'(dSym[i]);
            g.re = dOutRe[i];
            g.im = dOutIm[i];
            g.acceptCycle = 0;
            g.checkLat = 1'b1;
            applyStimulus(1'b1, dRe[i], dIm[i], 1'b1, 1'b1, g, 1'b1, acc);
            checkOutput("directed_accept", W'(acc), 32'd1);
        end
        drain();

        // Backpressure: three accepts fill the pipe, then it must refuse input
        // and hold the first result until out_ready returns.
        $display("[TB] backpressure");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, bpRe[i], bpIm[i], 1'b0, 1'b0, dummy, 1'b0, acc);
            checkOutput("bp_accept", W'(acc), 32'd1);
        end
        repeat (3) begin
            applyStimulus(1'b1, bpRe[3], bpIm[3], 1'b0, 1'b0, dummy, 1'b0, acc);
            checkOutput("bp_in_ready", W'(in_ready), 32'd0);
            checkOutput("bp_out_valid", W'(out_valid), 32'd1);
        end
        for (int i = 3; i < 5; i++) begin
            acc = 1'b0;
            n = 0;
            while (!acc && n < 10) begin
                applyStimulus(1'b1, bpRe[i], bpIm[i], 1'b1, 1'b0, dummy, 1'b0, acc);
                n++;
            end
            checkOutput("bp_late_accept", W'(acc), 32'd1);
        end
        drain();

        // Reset with samples in flight: everything in the pipe is dropped.
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, -500, 20, 1'b1, 1'b0, dummy, 1'b0, acc);
        applyStimulus(1'b1, 40, 900, 1'b1, 1'b0, dummy, 1'b0, acc);
        applyStimulus(1'b1, -70, -75, 1'b1, 1'b0, dummy, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        checkOutput("midrst_out_valid", W'(out_valid), 32'd0);
        checkOutput("midrst_out_sym", W'(out_sym), 32'd7);
        checkOutput("midrst_out_real", out_real, 32'd0);
        checkOutput("midrst_out_imag", out_imag, 32'd0);
        checkOutput("midrst_in_ready", W'(in_ready), 32'd1);
`ifdef PSK8_SLICER_ERR_EN
        checkOutput("midrst_out_err", W'(out_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, dummy, 1'b0, acc);
            checkOutput("post_rst_no_output", W'(out_valid), 32'd0);
        end

        // Random traffic with random backpressure.
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            vIn = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                rv = int'($urandom_range(0, 600)) - 300;
                iv = int'($urandom_range(0, 600)) - 300;
            end else begin
                rv = int'($urandom_range(0, 32'h7FFF_FFFE)) - 1073741823;
                iv = int'($urandom_range(0, 32'h7FFF_FFFE)) - 1073741823;
            end
            applyStimulus(vIn, rv, iv, rdy, 1'b0, dummy, 1'b0, acc);
        end
        drain();

        in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
